mesh_job_scheduler: RTL and testbench

Sequencer sitting in front of the 2-D MAC mesh. It accepts matrix-vector jobs over a valid/ready handshake and, when required, streams the ROWS×COLS weight set from a weight store into the mesh configuration port. It then pulses the mesh start, waits the fixed compute latency, and returns the captured result vector over a second valid/ready handshake. It replaces hand-driven preload/start sequencing at the top level.

---
 rtl/mesh_job_scheduler.sv | 162 ++++++++++++++++
 tb/tb_mesh_job_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_job_scheduler.sv
// Job sequencer for the 2-D MAC mesh: accepts a vector job, optionally streams the
// weight set into the mesh configuration port, starts the mesh and returns the result.
module mesh_job_scheduler #(
  parameter int DW          = 8,
  parameter int ROWS        = 16,
  parameter int COLS        = 12,
  parameter int ROW_W       = 4,
  parameter int COL_W       = 4,
  parameter int ACC_W       = 16,
  parameter int CYCLE_W     = 5,
  parameter int COMPUTE_LAT = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic                     job_reload,
  input  logic [COLS*DW-1:0]       job_x,
  output logic                     wt_rd_en,
  output logic [ROW_W+COL_W-1:0]   wt_rd_addr,
  input  logic [DW-1:0]            wt_rdata,
  output logic                     cfg_valid,
  output logic [ROW_W+COL_W-1:0]   cfg_addr,
  output logic [DW-1:0]            cfg_data,
  output logic                     mesh_start,
  output logic [COLS*DW-1:0]       x_vector_flat,
  input  logic [ROWS*ACC_W-1:0]    mesh_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ROWS*ACC_W-1:0]    res_data,
  output logic                     weights_loaded,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_TAIL,
    S_START,
    S_COMPUTE,
    S_OUTPUT
  } state_e;

  state_e                   state_q;
  logic                     job_ready_q;
  logic                     wt_rd_en_q;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic                     cfg_valid_q;
  logic [ROW_W+COL_W-1:0]   cfg_addr_q;
  logic                     mesh_start_q;
  logic [COLS*DW-1:0]       x_q;
  logic [CYCLE_W-1:0]       cnt_q;
  logic                     res_valid_q;
  logic [ROWS*ACC_W-1:0]    res_data_q;
  logic                     weights_loaded_q;
  logic                     last_addr;

  // Row-major address walk; column wraps at COLS-1 so codes col >= COLS never appear.
  always_comb begin
    last_addr = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));
    row_d     = row_q;
    col_d     = col_q + 1'b1;
    if (col_q == COL_W'(COLS - 1)) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      job_ready_q      <= 1'b1;
      wt_rd_en_q       <= 1'b0;
      row_q            <= '0;
      col_q            <= '0;
      cfg_valid_q      <= 1'b0;
      cfg_addr_q       <= '0;
      mesh_start_q     <= 1'b0;
      x_q              <= '0;
      cnt_q            <= '0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
      weights_loaded_q <= 1'b0;
    end else begin
      // The config port is the read strobe/address delayed to line up with read data.
      cfg_valid_q  <= wt_rd_en_q;
      cfg_addr_q   <= {row_q, col_q};
      mesh_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (job_valid && job_ready_q) begin
            x_q         <= job_x;
            job_ready_q <= 1'b0;
            if (job_reload || !weights_loaded_q) begin
              state_q          <= S_LOAD;
              weights_loaded_q <= 1'b0;
              wt_rd_en_q       <= 1'b1;
              row_q            <= '0;
              col_q            <= '0;
            end else begin
              state_q      <= S_START;
              mesh_start_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (last_addr) begin
            wt_rd_en_q <= 1'b0;
            state_q    <= S_LOAD_TAIL;
          end else begin
            row_q <= row_d;
            col_q <= col_d;
          end
        end
        S_LOAD_TAIL: begin
          weights_loaded_q <= 1'b1;
          mesh_start_q     <= 1'b1;
          state_q          <= S_START;
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (cnt_q == CYCLE_W'(COMPUTE_LAT - 1)) begin
            res_data_q  <= mesh_result;
            res_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // job_ready is forced low while rst is held so no job slips in during reset.
  assign job_ready      = job_ready_q & ~rst;
  assign wt_rd_en       = wt_rd_en_q;
  assign wt_rd_addr     = {row_q, col_q};
  assign cfg_valid      = cfg_valid_q;
  assign cfg_addr       = cfg_addr_q;
  assign cfg_data       = cfg_valid_q ? wt_rdata : '0;
  assign mesh_start     = mesh_start_q;
  assign x_vector_flat  = x_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign weights_loaded = weights_loaded_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mesh_job_scheduler.sv
// Scoreboard bench for mesh_job_scheduler: a job-level predictor queues expected
// config writes, start pulses and results; a monitor checks them as the DUT emits them.
module tb_mesh_job_scheduler;

  localparam int DW = 8, ROWS = 16, COLS = 12, ROW_W = 4, COL_W = 4;
  localparam int ACC_W = 16, CYCLE_W = 5, LAT = 28;
  localparam int N = ROWS * COLS;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  addr;
    logic [7:0]  data;
  } cfg_t;

  typedef struct {
    int unsigned              cyc;
    logic [ROWS*ACC_W-1:0]    data;
  } res_t;

  logic                   clk, rst;
  logic                   job_valid, job_ready, job_reload;
  logic [COLS*DW-1:0]     job_x;
  logic                   wt_rd_en;
  logic [ROW_W+COL_W-1:0] wt_rd_addr;
  logic [DW-1:0]          wt_rdata;
  logic                   cfg_valid;
  logic [ROW_W+COL_W-1:0] cfg_addr;
  logic [DW-1:0]          cfg_data;
  logic                   mesh_start;
  logic [COLS*DW-1:0]     x_vector_flat;
  logic [ROWS*ACC_W-1:0]  mesh_result;
  logic                   res_valid, res_ready;
  logic [ROWS*ACC_W-1:0]  res_data;
  logic                   weights_loaded, busy;

  mesh_job_scheduler #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
    .ACC_W(ACC_W), .CYCLE_W(CYCLE_W), .COMPUTE_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_reload(job_reload), .job_x(job_x),
    .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rdata(wt_rdata),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .mesh_start(mesh_start), .x_vector_flat(x_vector_flat), .mesh_result(mesh_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .weights_loaded(weights_loaded), .busy(busy)
  );

  int unsigned cyc = 0;
  int          vectors = 0;
  int          errs = 0;
  cfg_t        cfg_q[$];
  int unsigned start_q[$];
  res_t        res_q[$];
  int unsigned acc_cnt = 0, done_cnt = 0, done_cyc = '1;
  logic        m_wl = 1'b0;
  logic [COLS*DW-1:0] m_x = '0;

  // Mesh result is a pseudo-random function of the cycle number so any capture cycle is predictable.
  function automatic logic [ROWS*ACC_W-1:0] mres_f(int unsigned c);
    logic [ROWS*ACC_W-1:0] v;
    for (int i = 0; i < ROWS; i++)
      v[i*ACC_W +: ACC_W] = 16'((c * 32'd2654435761) >> i) ^ 16'(i * 777 + 3);
    return v;
  endfunction

  assign mesh_result = mres_f(cyc);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Weight store: one-cycle read latency, contents addr ^ 0x5A.
  initial forever begin
    @(posedge clk);
    wt_rdata <= wt_rd_en ? (wt_rd_addr ^ 8'h5A) : 8'($urandom);
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at cycle %0d, want finished", cyc);
    $fatal(1, "timeout");
  end

  // Predictor: reacts to accepted jobs using only the scheduling rules.
  initial begin
    int unsigned t, st;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        m_wl = 1'b0;
        m_x  = '0;
      end else if (job_valid && acc_cnt == done_cnt && done_cyc != cyc) begin
        t   = cyc;
        m_x = job_x;
        if (job_reload || !m_wl) begin
          for (int unsigned k = 0; k < N; k++) begin
            a = {4'(k / COLS), 4'(k % COLS)};
            cfg_q.push_back('{t + 2 + k, a, a ^ 8'h5A});
          end
          st   = t + N + 2;
          m_wl = 1'b1;
        end else begin
          st = t + 1;
        end
        start_q.push_back(st);
        res_q.push_back('{st + 1 + LAT, mres_f(st + LAT)});
        acc_cnt++;
      end
    end
  end

  // Monitor: compares DUT activity against the queued expectations.
  initial begin
    logic prev_rst;
    logic res_act;
    logic exp_idle;
    res_t res_exp;
    prev_rst = 1'b1;
    res_act  = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc != 0) begin
        while (cfg_q.size() != 0 && cfg_q[0].cyc < cyc) begin
          errs++;
          $display("FAIL cfg_missing: got no write at cycle %0d, want addr %h", cfg_q[0].cyc, cfg_q[0].addr);
          cfg_q.delete(0);
        end
        if (cfg_valid) begin
          vectors++;
          if (cfg_q.size() == 0 || cfg_q[0].cyc != cyc) begin
            errs++;
            $display("FAIL cfg_unexpected: got write addr %h at cycle %0d, want none", cfg_addr, cyc);
          end else begin
            if (cfg_addr !== cfg_q[0].addr || cfg_data !== cfg_q[0].data || weights_loaded !== 1'b0) begin
              errs++;
              $display("FAIL cfg_write: got addr %h data %h wl %b, want addr %h data %h wl 0",
                       cfg_addr, cfg_data, weights_loaded, cfg_q[0].addr, cfg_q[0].data);
            end
            cfg_q.delete(0);
          end
        end

        while (start_q.size() != 0 && start_q[0] < cyc) begin
          errs++;
          $display("FAIL start_missing: got no mesh_start at cycle %0d, want one", start_q[0]);
          start_q.delete(0);
        end
        if (mesh_start) begin
          vectors++;
          if (start_q.size() == 0 || start_q[0] != cyc) begin
            errs++;
            $display("FAIL start_unexpected: got mesh_start at cycle %0d, want none", cyc);
          end else begin
            if (weights_loaded !== 1'b1 || cfg_valid !== 1'b0) begin
              errs++;
              $display("FAIL start_state: got wl %b cfg_valid %b, want wl 1 cfg_valid 0", weights_loaded, cfg_valid);
            end
            start_q.delete(0);
          end
        end

        while (res_q.size() != 0 && res_q[0].cyc < cyc && !(res_act)) begin
          errs++;
          $display("FAIL res_missing: got no res_valid at cycle %0d, want one", res_q[0].cyc);
          res_q.delete(0);
        end
        if (res_valid) begin
          if (!res_act) begin
            vectors++;
            if (res_q.size() == 0 || res_q[0].cyc != cyc) begin
              errs++;
              $display("FAIL res_timing: got res_valid at cycle %0d, want cycle %0d",
                       cyc, (res_q.size() != 0) ? res_q[0].cyc : 0);
            end else begin
              res_exp = res_q[0];
              res_q.delete(0);
              res_act = 1'b1;
            end
          end
          if (res_act) begin
            vectors++;
            if (res_data !== res_exp.data || weights_loaded !== 1'b1) begin
              errs++;
              $display("FAIL res_data: got %h wl %b, want %h wl 1", res_data, weights_loaded, res_exp.data);
            end
            if (res_ready) begin
              res_act  = 1'b0;
              done_cnt = done_cnt + 1;
              done_cyc = cyc;
            end
          end
        end

        exp_idle = (acc_cnt == done_cnt) && (done_cyc != cyc || !res_valid) && !res_act;
        vectors++;
        if (rst) begin
          if (job_ready !== 1'b0) begin
            errs++;
            $display("FAIL ready_in_reset: got %b, want 0", job_ready);
          end
        end else if (job_ready !== (acc_cnt == done_cnt && done_cyc != cyc) || busy === job_ready) begin
          errs++;
          $display("FAIL ready_busy: got ready %b busy %b at cycle %0d, want ready %b",
                   job_ready, busy, cyc, (acc_cnt == done_cnt && done_cyc != cyc));
        end

        vectors++;
        if (x_vector_flat !== m_x) begin
          errs++;
          $display("FAIL x_vector: got %h, want %h", x_vector_flat, m_x);
        end

        if (prev_rst && !rst) begin
          vectors++;
          if ({weights_loaded, res_valid, wt_rd_en, cfg_valid, mesh_start, busy} !== 6'b0 || res_data !== '0) begin
            errs++;
            $display("FAIL post_reset: got wl %b rv %b rd %b cv %b ms %b busy %b rdata %h, want all 0",
                     weights_loaded, res_valid, wt_rd_en, cfg_valid, mesh_start, busy, res_data);
          end
        end

        if (rst) begin
          cfg_q.delete();
          start_q.delete();
          res_q.delete();
          res_act  = 1'b0;
          done_cnt = acc_cnt;
        end
      end
      prev_rst = rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic reload, input logic [COLS*DW-1:0] x, output int unsigned at);
    logic ok;
    ok         = 1'b0;
    at         = 0;
    job_reload = reload;
    job_x      = x;
    job_valid  = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = job_ready;
      if (ok) at = cyc;
      tick();
    end
    job_valid  = 1'b0;
    job_reload = 1'($urandom);
    job_x      = {$urandom, $urandom, $urandom};
    if (!ok) begin
      errs++;
      $display("FAIL accept_timeout: got no job_ready within 400 cycles, want acceptance");
    end
  endtask

  // mode 0: res_ready held high in advance; 1: hold low for 10 valid cycles; 2: random.
  task automatic wait_result(input int mode);
    logic hs;
    int   hold;
    hs        = 1'b0;
    hold      = 0;
    res_ready = (mode == 0);
    for (int i = 0; i < 600 && !hs; i++) begin
      @(negedge clk);
      hs = res_valid && res_ready;
      if (res_valid) hold++;
      tick();
      if (!hs) begin
        job_valid = (mode != 0) ? 1'($urandom) : 1'b0;
        job_x     = {$urandom, $urandom, $urandom};
        if (mode == 1) res_ready = (hold >= 10);
        if (mode == 2) res_ready = 1'($urandom);
      end else begin
        job_valid = 1'b0;
      end
    end
    if (!hs) begin
      errs++;
      $display("FAIL result_timeout: got no result handshake within 600 cycles, want one");
    end
  endtask

  initial begin
    int unsigned at, prev_at;
    rst        = 1'b1;
    job_valid  = 1'b0;
    job_reload = 1'b0;
    job_x      = '0;
    res_ready  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Forced load on first job, then a cached-weights job with a held result.
    send_job(1'b0, {$urandom, $urandom, $urandom}, at);
    wait_result(2);
    send_job(1'b0, {$urandom, $urandom, $urandom}, at);
    wait_result(1);
    send_job(1'b1, {$urandom, $urandom, $urandom}, at);
    wait_result(0);

    // Reset in the middle of a reload, then a plain job must reload everything.
    send_job(1'b1, {$urandom, $urandom, $urandom}, at);
    repeat (50) tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    res_ready = 1'b0;
    tick();
    send_job(1'b0, {$urandom, $urandom, $urandom}, at);
    wait_result(0);

    // Back-to-back jobs with res_ready tied high.
    prev_at = 0;
    for (int j = 0; j < 4; j++) begin
      send_job(1'b0, {$urandom, $urandom, $urandom}, at);
      if (j != 0) begin
        vectors++;
        if (at - prev_at != LAT + 3) begin
          errs++;
          $display("FAIL b2b_spacing: got %0d cycles, want %0d", at - prev_at, LAT + 3);
        end
      end
      prev_at = at;
      wait_result(0);
    end

    for (int j = 0; j < 10; j++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_job(1'($urandom_range(0, 3) == 0), {$urandom, $urandom, $urandom}, at);
      wait_result(int'($urandom_range(0, 2)));
    end

    job_valid = 1'b0;
    repeat (5) tick();
    vectors++;
    if (cfg_q.size() != 0 || start_q.size() != 0 || res_q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d cfg %0d start %0d res pending, want 0 0 0",
               cfg_q.size(), start_q.size(), res_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
